zimbo_exec_monitor: RTL and testbench

//  Synthesizable run monitor for the zimbo core, sitting beside zimbotop on the

---
 rtl/zimbo_exec_monitor_if.sv | 32 +++
 rtl/zimbo_exec_monitor.sv | 134 +++++++++++++
 tb/tb_zimbo_exec_monitor.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/zimbo_exec_monitor_if.sv
// Snoop bus between the zimbo core side (master) and the run monitor (slave).
// Carries the core activity being observed plus the monitor's status and counts.
interface zimbo_exec_monitor_if #(
  parameter int OPW = 5,
  parameter int AW  = 16,
  parameter int CW  = 32
);
  logic           start;
  logic           clr;
  logic [OPW-1:0] opcode;
  logic           memwr_en;
  logic [AW-1:0]  addrm;

  logic           busy;
  logic           halted;
  logic           timed_out;
  logic           done;
  logic           watch_hit;
  logic [CW-1:0]  cycle_count;
  logic [CW-1:0]  wr_count;
  logic [AW-1:0]  last_wr_addr;

  modport master (
    output start, clr, opcode, memwr_en, addrm,
    input  busy, halted, timed_out, done, watch_hit, cycle_count, wr_count, last_wr_addr
  );

  modport slave (
    input  start, clr, opcode, memwr_en, addrm,
    output busy, halted, timed_out, done, watch_hit, cycle_count, wr_count, last_wr_addr
  );
endinterface

// File: rtl/zimbo_exec_monitor.sv
// Run monitor for the zimbo core: times a run from start to HALT (or watchdog
// expiry) and tracks memory writes made during that run.
//
// state  | meaning
// IDLE   | no run since reset/clear
// RUN    | counting clocks and writes
// HALTED | HALT opcode seen, counts frozen
// TMO    | watchdog expired, counts frozen
module zimbo_exec_monitor #(
  parameter int             OPW        = 5,
  parameter logic [OPW-1:0] HALT_OP    = 5'b11111,
  parameter int             AW         = 16,
  parameter int             CW         = 32,
  parameter int             TIMEOUT    = 0,
  parameter bit             WATCH_EN   = 1'b0,
  parameter logic [AW-1:0]  WATCH_ADDR = 16'hFFFF
) (
  input  logic                        clock,
  input  logic                        reset_n,
  zimbo_exec_monitor_if.slave         bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    TMO    = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_t        state_q,        state_d;
  logic          busy_q,         busy_d;
  logic          halted_q,       halted_d;
  logic          timed_out_q,    timed_out_d;
  logic          done_q,         done_d;
  logic          watch_hit_q,    watch_hit_d;
  logic [CW-1:0] cycle_count_q,  cycle_count_d;
  logic [CW-1:0] wr_count_q,     wr_count_d;
  logic [AW-1:0] last_wr_addr_q, last_wr_addr_d;

  logic [CW-1:0] cycle_inc;
  logic [CW-1:0] wr_inc;

  always_comb begin
    cycle_inc = (cycle_count_q == CNT_MAX) ? cycle_count_q : cycle_count_q + CNT_ONE;
    wr_inc    = (wr_count_q == CNT_MAX) ? wr_count_q : wr_count_q + CNT_ONE;

    state_d        = state_q;
    done_d         = 1'b0;
    watch_hit_d    = watch_hit_q;
    cycle_count_d  = cycle_count_q;
    wr_count_d     = wr_count_q;
    last_wr_addr_d = last_wr_addr_q;

    if (bus.clr) begin
      state_d        = IDLE;
      watch_hit_d    = 1'b0;
      cycle_count_d  = '0;
      wr_count_d     = '0;
      last_wr_addr_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          // Writes are captured on every RUN edge, including the terminating one.
          if (bus.memwr_en) begin
            wr_count_d     = wr_inc;
            last_wr_addr_d = bus.addrm;
            if (WATCH_EN && (bus.addrm == WATCH_ADDR)) watch_hit_d = 1'b1;
          end
          if (bus.opcode == HALT_OP) begin
            state_d = HALTED;
            done_d  = 1'b1;
          end else if ((TIMEOUT != 0) && (cycle_count_q == TMO_LAST)) begin
            cycle_count_d = cycle_inc;
            state_d       = TMO;
            done_d        = 1'b1;
          end else begin
            cycle_count_d = cycle_inc;
          end
        end
        default: begin
          if (bus.start) begin
            state_d        = RUN;
            watch_hit_d    = 1'b0;
            cycle_count_d  = '0;
            wr_count_d     = '0;
            last_wr_addr_d = '0;
          end
        end
      endcase
    end

    busy_d      = (state_d == RUN);
    halted_d    = (state_d == HALTED);
    timed_out_d = (state_d == TMO);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      halted_q       <= 1'b0;
      timed_out_q    <= 1'b0;
      done_q         <= 1'b0;
      watch_hit_q    <= 1'b0;
      cycle_count_q  <= '0;
      wr_count_q     <= '0;
      last_wr_addr_q <= '0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      halted_q       <= halted_d;
      timed_out_q    <= timed_out_d;
      done_q         <= done_d;
      watch_hit_q    <= watch_hit_d;
      cycle_count_q  <= cycle_count_d;
      wr_count_q     <= wr_count_d;
      last_wr_addr_q <= last_wr_addr_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.halted       = halted_q;
  assign bus.timed_out    = timed_out_q;
  assign bus.done         = done_q;
  assign bus.watch_hit    = watch_hit_q;
  assign bus.cycle_count  = cycle_count_q;
  assign bus.wr_count     = wr_count_q;
  assign bus.last_wr_addr = last_wr_addr_q;

endmodule

// File: tb/tb_zimbo_exec_monitor.sv
// Directed bench for zimbo_exec_monitor: three configurations share one stimulus
// stream (a: watch at 16'h00F0, b: TIMEOUT=8, c: CW=4).
module tb_zimbo_exec_monitor;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, clr, memwr_en;
  logic [4:0]  opcode;
  logic [15:0] addrm;

  int n_chk  = 0;
  int n_fail = 0;

  zimbo_exec_monitor_if #(.CW(32)) if_a ();
  zimbo_exec_monitor_if #(.CW(32)) if_b ();
  zimbo_exec_monitor_if #(.CW(4))  if_c ();

  assign if_a.start = start;    assign if_b.start = start;    assign if_c.start = start;
  assign if_a.clr = clr;        assign if_b.clr = clr;        assign if_c.clr = clr;
  assign if_a.opcode = opcode;  assign if_b.opcode = opcode;  assign if_c.opcode = opcode;
  assign if_a.memwr_en = memwr_en; assign if_b.memwr_en = memwr_en; assign if_c.memwr_en = memwr_en;
  assign if_a.addrm = addrm;    assign if_b.addrm = addrm;    assign if_c.addrm = addrm;

  zimbo_exec_monitor #(.WATCH_EN(1'b1), .WATCH_ADDR(16'h00F0)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(if_a));
  zimbo_exec_monitor #(.TIMEOUT(8)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(if_b));
  zimbo_exec_monitor #(.CW(4)) dut_c (
    .clock(clock), .reset_n(reset_n), .bus(if_c));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; clr = 1'b0;
    opcode = 5'd0; memwr_en = 1'b0; addrm = 16'h0000;
    #12;
    chk("rst_busy",   32'(if_a.busy), 32'd0);
    chk("rst_halted", 32'(if_a.halted), 32'd0);
    chk("rst_tmo",    32'(if_a.timed_out), 32'd0);
    chk("rst_done",   32'(if_a.done), 32'd0);
    chk("rst_cycles", if_a.cycle_count, 32'd0);
    chk("rst_wr",     if_a.wr_count, 32'd0);
    chk("rst_last",   32'(if_a.last_wr_addr), 32'd0);
    chk("rst_watch",  32'(if_a.watch_hit), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // write while idle must be ignored
    memwr_en = 1'b1; addrm = 16'h0055;
    tick();
    chk("idle_wr_count", if_a.wr_count, 32'd0);
    chk("idle_wr_addr",  32'(if_a.last_wr_addr), 32'd0);
    memwr_en = 1'b0;

    // run: 10 non-halt RUN clocks with writes at 0x10/0x20/0x30
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_busy0",   32'(if_a.busy), 32'd1);
    chk("run_cycles0", if_a.cycle_count, 32'd0);
    for (int i = 0; i < 10; i++) begin
      memwr_en = (i == 2) || (i == 4) || (i == 6);
      addrm    = (i == 2) ? 16'h0010 : (i == 4) ? 16'h0020 : (i == 6) ? 16'h0030 : 16'h0000;
      tick();
      if (i == 7) begin
        chk("tmo_flag",   32'(if_b.timed_out), 32'd1);
        chk("tmo_cycles", if_b.cycle_count, 32'd8);
        chk("tmo_done",   32'(if_b.done), 32'd1);
        chk("tmo_busy",   32'(if_b.busy), 32'd0);
      end
      if (i == 8) begin
        chk("tmo_done_once", 32'(if_b.done), 32'd0);
        chk("tmo_held",      32'(if_b.timed_out), 32'd1);
      end
    end
    memwr_en = 1'b0;
    chk("run_cycles10", if_a.cycle_count, 32'd10);
    chk("run_busy10",   32'(if_a.busy), 32'd1);
    chk("run_wr3",      if_a.wr_count, 32'd3);
    chk("run_last30",   32'(if_a.last_wr_addr), 32'h0030);
    chk("run_watch0",   32'(if_a.watch_hit), 32'd0);
    chk("c_cycles10",   32'(if_c.cycle_count), 32'd10);

    // halt with a write to the watched address on the same edge
    opcode = 5'b11111; memwr_en = 1'b1; addrm = 16'h00F0;
    tick();
    opcode = 5'd0; memwr_en = 1'b0; addrm = 16'h0000;
    chk("halt_flag",   32'(if_a.halted), 32'd1);
    chk("halt_done",   32'(if_a.done), 32'd1);
    chk("halt_busy",   32'(if_a.busy), 32'd0);
    chk("halt_cycles", if_a.cycle_count, 32'd10);
    chk("halt_wr4",    if_a.wr_count, 32'd4);
    chk("halt_lastF0", 32'(if_a.last_wr_addr), 32'h00F0);
    chk("halt_watch",  32'(if_a.watch_hit), 32'd1);
    chk("b_tmo_wr",    if_b.wr_count, 32'd3);
    chk("b_tmo_last",  32'(if_b.last_wr_addr), 32'h0030);
    chk("b_watch_off", 32'(if_b.watch_hit), 32'd0);
    chk("b_tmo_cyc",   if_b.cycle_count, 32'd8);
    tick();
    chk("halt_done_once", 32'(if_a.done), 32'd0);
    chk("halt_held",      32'(if_a.halted), 32'd1);
    chk("halt_cyc_held",  if_a.cycle_count, 32'd10);
    chk("watch_sticky",   32'(if_a.watch_hit), 32'd1);

    // restart from HALTED / TMO clears counts and watch flag
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rs_watch",  32'(if_a.watch_hit), 32'd0);
    chk("rs_cycles", if_a.cycle_count, 32'd0);
    chk("rs_wr",     if_a.wr_count, 32'd0);
    chk("rs_last",   32'(if_a.last_wr_addr), 32'd0);
    chk("rs_busy",   32'(if_a.busy), 32'd1);
    chk("rs_b_tmo",  32'(if_b.timed_out), 32'd0);
    chk("rs_b_cyc",  if_b.cycle_count, 32'd0);

    // saturation on the 4-bit counter
    repeat (20) tick();
    chk("sat_c_cycles", 32'(if_c.cycle_count), 32'hF);
    chk("sat_c_busy",   32'(if_c.busy), 32'd1);
    chk("a_cycles20",   if_a.cycle_count, 32'd20);

    // async reset mid-run
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy",   32'(if_a.busy), 32'd0);
    chk("arst_cycles", if_a.cycle_count, 32'd0);
    chk("arst_done",   32'(if_a.done), 32'd0);
    chk("arst_c_cyc",  32'(if_c.cycle_count), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    chk("arst_idle", 32'(if_a.busy), 32'd0);
    chk("arst_no_done", 32'(if_a.done), 32'd0);

    // clr and start together: clr wins
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("clr_pre_cycles", if_a.cycle_count, 32'd2);
    clr = 1'b1; start = 1'b1;
    tick();
    clr = 1'b0; start = 1'b0;
    chk("clr_busy",   32'(if_a.busy), 32'd0);
    chk("clr_cycles", if_a.cycle_count, 32'd0);
    chk("clr_halted", 32'(if_a.halted), 32'd0);
    chk("clr_done",   32'(if_a.done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
